// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider: one quotient bit per clock, fixed latency, start/valid handshake.
// Signed (two's complement) operation is enabled by defining DIV_SIGNED_EN; otherwise operands are unsigned.
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Result_Valid,
  output logic             Busy,
  output logic             Div_Zero
);

  typedef enum logic [1:0] {IDLE, LOAD, CALC, FIX} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   a_reg, b_reg;
  logic [WIDTH-1:0]   divisor_reg, quo_reg;
  logic [WIDTH:0]     rem_reg;
  logic               sign_q_reg, sign_r_reg, dz_int_reg;
  logic [WIDTH-1:0]   quotient_reg, remainder_reg;
  logic               valid_reg, dz_reg;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               a_sign, b_sign;
  logic [WIDTH+1:0]   shifted, trial;
  logic               last_iter;

`ifdef DIV_SIGNED_EN
  // -MIN wraps to MIN, which read as unsigned is exactly its magnitude
  assign a_sign = a_reg[WIDTH-1];
  assign b_sign = b_reg[WIDTH-1];
  assign a_mag  = a_sign ? -a_reg : a_reg;
  assign b_mag  = b_sign ? -b_reg : b_reg;
`else
  assign a_sign = 1'b0;
  assign b_sign = 1'b0;
  assign a_mag  = a_reg;
  assign b_mag  = b_reg;
`endif

  // Extra top bit on the trial subtraction acts as the borrow/sign flag
  assign shifted   = {rem_reg, quo_reg[WIDTH-1]};
  assign trial     = shifted - {2'b00, divisor_reg};
  assign last_iter = (cnt_reg == CNT_W'(WIDTH - 1));

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    Busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        Busy = 1'b0;
        if (Start) state_next = LOAD;
      end
      LOAD: state_next = CALC;
      CALC: if (last_iter) state_next = FIX;
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt_reg       <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      divisor_reg   <= '0;
      quo_reg       <= '0;
      rem_reg       <= '0;
      sign_q_reg    <= 1'b0;
      sign_r_reg    <= 1'b0;
      dz_int_reg    <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      valid_reg     <= 1'b0;
      dz_reg        <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (Start) begin
            a_reg <= in_a;
            b_reg <= in_b;
          end
        end
        LOAD: begin
          quo_reg     <= a_mag;
          divisor_reg <= b_mag;
          rem_reg     <= '0;
          cnt_reg     <= '0;
          sign_q_reg  <= a_sign ^ b_sign;
          sign_r_reg  <= a_sign;
          dz_int_reg  <= (b_reg == '0);
        end
        CALC: begin
          if (!trial[WIDTH+1]) begin
            rem_reg <= trial[WIDTH:0];
            quo_reg <= {quo_reg[WIDTH-2:0], 1'b1};
          end else begin
            rem_reg <= shifted[WIDTH:0];
            quo_reg <= {quo_reg[WIDTH-2:0], 1'b0};
          end
          cnt_reg <= cnt_reg + 1'b1;
        end
        FIX: begin
          valid_reg <= 1'b1;
          dz_reg    <= dz_int_reg;
          // Divide-by-zero reports the dividend as given, never a sign-corrected magnitude
          if (dz_int_reg) begin
            quotient_reg  <= '1;
            remainder_reg <= a_reg;
          end else begin
            quotient_reg  <= sign_q_reg ? -quo_reg : quo_reg;
            remainder_reg <= sign_r_reg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign Quotient     = quotient_reg;
  assign Remainder    = remainder_reg;
  assign Result_Valid = valid_reg;
  assign Div_Zero     = dz_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases, handshake/reset behaviour and random vectors
// compared with a plain-arithmetic reference (signed reference used when DIV_SIGNED_EN is defined).
module tb_seq_divider;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         Start = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [W-1:0] Quotient, Remainder;
  logic         Result_Valid, Busy, Div_Zero;

  int n_checks = 0;
  int n_errors = 0;

  seq_divider #(.WIDTH(W), .CNT_W(6)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .in_a(in_a), .in_b(in_b),
    .Quotient(Quotient), .Remainder(Remainder), .Result_Valid(Result_Valid),
    .Busy(Busy), .Div_Zero(Div_Zero)
  );

  initial forever #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: truncating division, remainder follows the dividend
  task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
    int sa, sb;
    dz = (b == '0);
    if (b == '0) begin
      q = '1;
      r = a;
    end else begin
`ifdef DIV_SIGNED_EN
      sa = a;
      sb = b;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = '0;
      end else begin
        q = sa / sb;
        r = sa % sb;
      end
`else
      sa = 0;
      sb = 0;
      q = a / b;
      r = a % b;
`endif
    end
  endtask

  // One transaction: issue Start, wait (bounded) for Result_Valid, check results and timing
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eq, er;
    logic         edz;
    int           lat;
    ref_div(a, b, eq, er, edz);
    @(negedge CLK);
    in_a  = a;
    in_b  = b;
    Start = 1'b1;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    check("busy_after_start", W'(Busy), W'(1));
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge CLK);
      #1;
      if (Result_Valid) begin
        lat = k;
        break;
      end
    end
    check("latency", W'(lat), W'(LAT));
    check("quotient", Quotient, eq);
    check("remainder", Remainder, er);
    check("div_zero", W'(Div_Zero), W'(edz));
    check("busy_at_valid", W'(Busy), W'(0));
    if (b != '0) check("invariant", a, Quotient * b + Remainder);
    $display("div a=%h b=%h -> q=%h r=%h dz=%b lat=%0d", a, b, Quotient, Remainder, Div_Zero, lat);
    @(posedge CLK);
    #1;
    check("valid_one_cycle", W'(Result_Valid), W'(0));
  endtask

  initial begin
    int nv;
    int gap;
    logic [W-1:0] ra, rb, eq, er;
    logic         edz;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check("rst_quotient", Quotient, '0);
    check("rst_remainder", Remainder, '0);
    check("rst_valid", W'(Result_Valid), W'(0));
    check("rst_busy", W'(Busy), W'(0));
    check("rst_divzero", W'(Div_Zero), W'(0));
    @(negedge CLK);
    RST = 1'b1;

    // Basic and boundary cases
    run_div(32'd100, 32'd7);
    run_div(32'd5, 32'd0);
    run_div(32'd9, 32'd3);
    run_div(32'hFFFF_FFF0, 32'd2);
    run_div(32'd3, 32'd10);
    run_div(32'hFFFF_FF9C, 32'd7);
    run_div(32'd100, 32'hFFFF_FFF9);
    run_div(32'h8000_0000, 32'hFFFF_FFFF);
    run_div(32'h8000_0000, 32'd0);
    run_div(32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Reset in the middle of a division aborts it
    run_div(32'd100, 32'd7);
    @(negedge CLK);
    in_a  = 32'd1000;
    in_b  = 32'd3;
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    repeat (10) @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("midrst_quotient", Quotient, '0);
    check("midrst_remainder", Remainder, '0);
    check("midrst_valid", W'(Result_Valid), W'(0));
    check("midrst_busy", W'(Busy), W'(0));
    check("midrst_divzero", W'(Div_Zero), W'(0));
    @(negedge CLK);
    RST = 1'b1;
    nv = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge CLK);
      #1;
      if (Result_Valid) nv++;
    end
    check("midrst_no_result", W'(nv), W'(0));
    $display("reset mid-division: results after reset=%0d", nv);

    // Start pulsed while busy is ignored
    @(negedge CLK);
    in_a  = 32'd77;
    in_b  = 32'd5;
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    repeat (9) @(negedge CLK);
    in_a  = 32'd1;
    in_b  = 32'd1;
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    nv = 0;
    for (int k = 0; k < 70; k++) begin
      @(posedge CLK);
      #1;
      if (Result_Valid) begin
        nv++;
        check("ignored_start_q", Quotient, 32'd15);
        check("ignored_start_r", Remainder, 32'd2);
      end
    end
    check("ignored_start_count", W'(nv), W'(1));
    $display("start while busy: results=%0d", nv);

    // Start held high: back-to-back results 35 cycles apart
    @(negedge CLK);
    in_a  = 32'd1234;
    in_b  = 32'd10;
    Start = 1'b1;
    gap = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge CLK);
      #1;
      if (Result_Valid) break;
    end
    check("b2b_first_valid", W'(Result_Valid), W'(1));
    @(posedge CLK);
    #1;
    Start = 1'b0;
    for (int k = 2; k <= 100; k++) begin
      @(posedge CLK);
      #1;
      if (Result_Valid) begin
        gap = k;
        break;
      end
    end
    check("b2b_gap", W'(gap), W'(LAT + 1));
    check("b2b_quotient", Quotient, 32'd123);
    check("b2b_remainder", Remainder, 32'd4);
    $display("back-to-back: gap=%0d q=%0d r=%0d", gap, Quotient, Remainder);
    repeat (40) @(posedge CLK);

    // Random vectors
    for (int i = 0; i < 150; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = W'($urandom_range(0, 20));
        1: rb = $urandom >> $urandom_range(0, 31);
        2: rb = -W'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      ref_div(ra, rb, eq, er, edz);
      run_div(ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
